// File: rtl/irq_ctrl.sv
// Vectored interrupt controller: per-channel edge/level pending latch, mask and priority encoder.
// Optional feature: define IRQ_MASK_EN to make ENA a writable register (otherwise constant all-enabled).
module irq_ctrl #(
    parameter int WIDTH = 18,
    parameter int VBITS = 4
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic [2**VBITS-1:0]   src,
    input  logic                  io_rd,
    input  logic                  io_wr,
    input  logic [1:0]            addr,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      dout,
    output logic                  irq,
    output logic [VBITS-1:0]      ivec,
    input  logic                  iack
);

    localparam int N = 2**VBITS;
    localparam logic [N-1:0] ALL_CH = {{(N-1){1'b1}}, 1'b0};

    logic [N-1:0]     pend;
    logic [N-1:0]     pend_nxt;
    logic [N-1:0]     src_d;
    logic [N-1:0]     mode;
    logic [N-1:0]     ena;
    logic [N-1:0]     active;
    logic [N-1:0]     set_v;
    logic [N-1:0]     clr_v;
    logic [N-1:0]     ack_v;
    logic [N-1:0]     din_ch;
    logic [VBITS-1:0] ivec_c;
    logic [WIDTH-1:0] rd_val;
    logic             wr_pend;
    logic             wr_mode;
    logic             wr_sw;

    assign din_ch  = din[N-1:0] & ALL_CH;
    assign wr_pend = io_wr && (addr == 2'd0);
    assign wr_mode = io_wr && (addr == 2'd2);
    assign wr_sw   = io_wr && (addr == 2'd3);

    generate
        if (WIDTH > N) begin : g_pad
            logic unused_din;
            assign unused_din = ^din[WIDTH-1:N];
        end
    endgenerate

`ifdef IRQ_MASK_EN
    logic wr_ena;
    assign wr_ena = io_wr && (addr == 2'd1);

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            ena <= ALL_CH;
        end else if (wr_ena) begin
            ena <= din_ch;
        end
    end
`else
    assign ena = ALL_CH;
`endif

    // Highest enabled pending channel wins; channel 0 never participates.
    assign active = pend & ena & ALL_CH;

    always_comb begin
        ivec_c = '0;
        for (int i = 1; i < N; i++) begin
            if (active[i]) begin
                ivec_c = VBITS'(i);
            end
        end
    end

    assign ivec = ivec_c;
    assign irq  = (ivec_c != '0);

    // Edge channels: set beats clear on the same bit. Level channels simply mirror src.
    always_comb begin
        ack_v    = iack ? (N'(1) << ivec_c) : '0;
        set_v    = (src & ~src_d) | (wr_sw ? din_ch : '0);
        clr_v    = ack_v | (wr_pend ? din_ch : '0);
        pend_nxt = ((mode & (set_v | (pend & ~clr_v))) | (~mode & src)) & ALL_CH;
    end

    always_comb begin
        rd_val = '0;
        case (addr)
            2'd0:    rd_val[N-1:0]     = pend;
            2'd1:    rd_val[N-1:0]     = ena;
            2'd2:    rd_val[N-1:0]     = mode;
            default: rd_val[VBITS-1:0] = ivec_c;
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            pend  <= '0;
            src_d <= '0;
            mode  <= ALL_CH;
            dout  <= '0;
        end else begin
            pend  <= pend_nxt;
            src_d <= src;
            if (wr_mode) begin
                mode <= din_ch;
            end
            // rd_val reflects pre-write state, so a combined read/write returns the old value.
            if (io_rd) begin
                dout <= rd_val;
            end
        end
    end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: vector table fed through an expectation queue,
// plus hand-written mask and asynchronous-reset sequences.
module tb_irq_ctrl;

    localparam int VBITS = 4;
    localparam int N     = 16;
    localparam int WIDTH = 18;

    logic             clk = 1'b0;
    logic             arstn = 1'b0;
    logic [N-1:0]     src = '0;
    logic             io_rd = 1'b0;
    logic             io_wr = 1'b0;
    logic [1:0]       addr = '0;
    logic [WIDTH-1:0] din = '0;
    logic [WIDTH-1:0] dout;
    logic             irq;
    logic [VBITS-1:0] ivec;
    logic             iack = 1'b0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [N-1:0]     src;
        logic             iack;
        logic             rd;
        logic             wr;
        logic [1:0]       addr;
        logic [WIDTH-1:0] din;
        logic             exp_irq;
        logic [VBITS-1:0] exp_ivec;
        logic             chk_dout;
        logic [WIDTH-1:0] exp_dout;
    } vec_t;

    typedef struct {
        logic             exp_irq;
        logic [VBITS-1:0] exp_ivec;
        logic             chk_dout;
        logic [WIDTH-1:0] exp_dout;
        int               idx;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];

    irq_ctrl #(.WIDTH(WIDTH), .VBITS(VBITS)) dut (
        .clk   (clk),
        .arstn (arstn),
        .src   (src),
        .io_rd (io_rd),
        .io_wr (io_wr),
        .addr  (addr),
        .din   (din),
        .dout  (dout),
        .irq   (irq),
        .ivec  (ivec),
        .iack  (iack)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s (step %0d): got 0x%0h, expected 0x%0h", name, idx, act, exp);
        end
    endtask

    function automatic void add(input logic [N-1:0] s, input logic ia, input logic rd, input logic wr,
                                input logic [1:0] a, input logic [WIDTH-1:0] d, input logic ei,
                                input logic [VBITS-1:0] ev, input logic cd, input logic [WIDTH-1:0] ed);
        vec_t v;
        v = '{s, ia, rd, wr, a, d, ei, ev, cd, ed};
        tbl.push_back(v);
    endfunction

    task automatic check_output();
        exp_t e;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard_empty: got 0 entries, expected 1");
        end else begin
            e = sb.pop_front();
            check("irq", e.idx, 32'(irq), 32'(e.exp_irq));
            check("ivec", e.idx, 32'(ivec), 32'(e.exp_ivec));
            if (e.chk_dout) begin
                check("dout", e.idx, 32'(dout), 32'(e.exp_dout));
            end
        end
    endtask

    // Drive one cycle of stimulus away from the active edge, then check just after it.
    task automatic apply_stimulus(input vec_t v, input int idx);
        exp_t e;
        @(negedge clk);
        src   = v.src;
        iack  = v.iack;
        io_rd = v.rd;
        io_wr = v.wr;
        addr  = v.addr;
        din   = v.din;
        e = '{v.exp_irq, v.exp_ivec, v.chk_dout, v.exp_dout, idx};
        sb.push_back(e);
        @(posedge clk);
        #1;
        check_output();
    endtask

    task automatic step(input logic [N-1:0] s, input logic ia, input logic rd, input logic wr,
                        input logic [1:0] a, input logic [WIDTH-1:0] d, input logic ei,
                        input logic [VBITS-1:0] ev, input logic cd, input logic [WIDTH-1:0] ed, input int idx);
        vec_t v;
        v = '{s, ia, rd, wr, a, d, ei, ev, cd, ed};
        apply_stimulus(v, idx);
    endtask

    initial begin
        logic [WIDTH-1:0] ena_wr;
`ifdef IRQ_MASK_EN
        ena_wr = 18'h0FFFE;
`else
        ena_wr = 18'h00000;
`endif
        //    src       ia rd wr a  din        irq ivec cd dout
        add(16'h0000, 0, 0, 0, 0, 18'h0,     0, 0, 0, 18'h0);     // 0 idle
        add(16'h0008, 0, 0, 0, 0, 18'h0,     1, 3, 0, 18'h0);     // 1 edge on 3
        add(16'h0008, 0, 0, 0, 0, 18'h0,     1, 3, 0, 18'h0);     // 2 held pending
        add(16'h0008, 1, 0, 0, 0, 18'h0,     0, 0, 0, 18'h0);     // 3 ack 3
        add(16'h0008, 0, 0, 0, 0, 18'h0,     0, 0, 0, 18'h0);     // 4 no retrigger
        add(16'h0008, 0, 1, 0, 0, 18'h0,     0, 0, 1, 18'h0);     // 5 read PEND
        add(16'h002A, 0, 0, 0, 0, 18'h0,     1, 5, 0, 18'h0);     // 6 1 and 5 rise
        add(16'h002A, 1, 0, 0, 0, 18'h0,     1, 1, 0, 18'h0);     // 7 ack 5
        add(16'h002A, 1, 0, 0, 0, 18'h0,     0, 0, 0, 18'h0);     // 8 ack 1
        add(16'h002A, 0, 0, 1, 3, 18'h0090,  1, 7, 0, 18'h0);     // 9 SWSET 4,7
        add(16'h002A, 0, 1, 0, 3, 18'h0,     1, 7, 1, 18'h7);     // 10 read vector
        add(16'h002A, 0, 0, 1, 0, 18'h0080,  1, 4, 0, 18'h0);     // 11 W1C 7
        add(16'h002A, 0, 1, 0, 0, 18'h0,     1, 4, 1, 18'h0010);  // 12 read PEND
        add(16'h003A, 1, 0, 0, 0, 18'h0,     1, 4, 0, 18'h0);     // 13 ack vs new edge on 4
        add(16'h003A, 1, 0, 0, 0, 18'h0,     0, 0, 0, 18'h0);     // 14 ack 4
        add(16'h003A, 0, 0, 1, 3, 18'h0004,  1, 2, 0, 18'h0);     // 15 SWSET 2
        add(16'h003A, 0, 1, 1, 0, 18'h0004,  0, 0, 1, 18'h0004);  // 16 read+W1C same cycle
        add(16'h003A, 0, 0, 1, 2, 18'h0,     0, 0, 0, 18'h0);     // 17 all level
        add(16'h003A, 0, 0, 0, 0, 18'h0,     1, 5, 0, 18'h0);     // 18 level follows src
        add(16'h003A, 1, 0, 0, 0, 18'h0,     1, 5, 0, 18'h0);     // 19 ack ignored on level
        add(16'h0004, 0, 1, 0, 2, 18'h0,     1, 2, 1, 18'h0);     // 20 read MODE
        add(16'h0004, 1, 0, 0, 0, 18'h0,     1, 2, 0, 18'h0);     // 21 ack ignored
        add(16'h0000, 0, 0, 0, 0, 18'h0,     0, 0, 0, 18'h0);     // 22 level drop
        add(16'h0000, 0, 0, 1, 1, ena_wr,    0, 0, 0, 18'h0);     // 23 write ENA
        add(16'h0000, 0, 1, 0, 1, 18'h0,     0, 0, 1, 18'h0FFFE); // 24 read ENA
        add(16'h0004, 0, 0, 1, 2, 18'h0FFFF, 1, 2, 0, 18'h0);     // 25 back to edge
        add(16'h0004, 0, 0, 0, 0, 18'h0,     1, 2, 0, 18'h0);     // 26 PEND kept
        add(16'h0004, 1, 0, 0, 0, 18'h0,     0, 0, 0, 18'h0);     // 27 ack 2
        add(16'h0004, 0, 1, 0, 2, 18'h0,     0, 0, 1, 18'h0FFFE); // 28 read MODE

        #12;
        check("reset_irq", -1, 32'(irq), 32'h0);
        check("reset_ivec", -1, 32'(ivec), 32'h0);
        check("reset_dout", -1, 32'(dout), 32'h0);
        @(negedge clk);
        arstn = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply_stimulus(tbl[i], i);
        end

`ifdef IRQ_MASK_EN
        step(16'h0004, 0, 0, 1, 1, 18'h0,      0, 0, 0, 18'h0,      100);
        step(16'h0004, 0, 0, 1, 3, 18'h0080,   0, 0, 0, 18'h0,      101);
        step(16'h0004, 0, 1, 0, 0, 18'h0,      0, 0, 1, 18'h0080,   102);
        step(16'h0004, 0, 0, 1, 1, 18'h0FFFE,  1, 7, 0, 18'h0,      103);
        step(16'h0004, 0, 0, 1, 0, 18'h0080,   0, 0, 0, 18'h0,      104);
`endif

        // Build PEND=0x0106, load dout, then pull reset between clock edges.
        step(16'h0004, 0, 0, 1, 3, 18'h0106,   1, 8, 0, 18'h0,      200);
        step(16'h0004, 0, 1, 0, 0, 18'h0,      1, 8, 1, 18'h0106,   201);
        @(posedge clk);
        #2;
        io_rd = 1'b0;
        src   = 16'h0040;
        arstn = 1'b0;
        #1;
        check("async_irq", 202, 32'(irq), 32'h0);
        check("async_ivec", 202, 32'(ivec), 32'h0);
        check("async_dout", 202, 32'(dout), 32'h0);
        @(negedge clk);
        arstn = 1'b1;
        step(16'h0040, 0, 0, 0, 0, 18'h0,      1, 6, 0, 18'h0,      203);
        step(16'h0040, 0, 1, 0, 0, 18'h0,      1, 6, 1, 18'h0040,   204);

        check("sb_drained", 300, 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("[TB] FAIL timeout: got no finish, expected finish before 50000");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 18, meaning CPU data width; WIDTH >= 2**VBITS.
REQ-002 SHALL have parameter VBITS, default 4, meaning vector width; channels 1..2**VBITS-1; vector 0 means none.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port arstn  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port src  input  2**VBITS  interrupt sources, synchronous to clk; bit 0 ignored.
REQ-006 SHALL have port io_rd  input  1  register read strobe.
REQ-007 SHALL have port io_wr  input  1  register write strobe.
REQ-008 SHALL have port addr  input  2  register select.
REQ-009 SHALL have port din  input  WIDTH  write data.
REQ-010 SHALL have port dout  output  WIDTH  read data.
REQ-011 SHALL have port irq  output  1  interrupt request to CPU.
REQ-012 SHALL have port ivec  output  VBITS  vector of highest-priority active channel.
REQ-013 SHALL have port iack  input  1  CPU acknowledge of current ivec.

Function
REQ-014 Registers, low 2**VBITS bits, bit 0 reads 0, upper bits read 0: addr 0 PEND (read; write-1-to-clear), 1 ENA (rw), 2 MODE (rw; 1=edge, 0=level), 3 write SWSET (write-1-to-set PEND), read returns ivec zero-extended.
REQ-015 Edge channel: src registered into src_d each cycle; rising edge (src & ~src_d) sets PEND bit on the same clock edge where src is first sampled high.
REQ-016 Level channel: PEND bit loads src each cycle; iack, W1C and SWSET have no effect on it.
REQ-017 ivec combinational: highest index n with PEND[n] & ENA[n]; 0 if none; irq = (ivec != 0).
REQ-018 Latency: src rising in cycle k (sampled at edge k) -> irq and ivec valid during cycle k+1.
REQ-019 iack for one cycle clears PEND[ivec] of an edge channel; iack with ivec = 0 does nothing.
REQ-020 Simultaneous set (edge/SWSET) and clear (iack/W1C) on the same bit in one cycle: set wins.
REQ-021 Masked channels (ENA=0) still latch PEND; re-enabling raises irq the next cycle.
REQ-022 dout registered: loaded with selected register on the clock edge where io_rd=1; held otherwise.
REQ-023 Writing MODE edge->level or level->edge does not clear PEND; src_d keeps tracking.
REQ-024 io_rd and io_wr together in one cycle: write takes effect; dout shows pre-write value.

Reset
REQ-025 arstn low: PEND=0, src_d=0, MODE all ones (edge), ENA all ones (bit 0 = 0), dout=0, therefore irq=0, ivec=0.
REQ-026 Reset mid-handshake discards all pending state; first edge after release is detected relative to src_d=0.

Configuration
REQ-027 Macro IRQ_MASK_EN defined: ENA is a writable register per REQ-014, reset all ones.
REQ-028 IRQ_MASK_EN undefined: ENA is constant all ones (bit 0 = 0), writes to addr 1 ignored, reads return the constant; no ENA flops synthesised.

Verification
REQ-029 Edge: MODE=all edge, src[3] 0->1 held -> irq=1, ivec=3 next cycle; iack -> PEND=0, irq=0; src held high does not re-trigger.
REQ-030 Priority: src[1] and src[5] rise together -> ivec=5; iack -> ivec=1; iack -> ivec=0.
REQ-031 Level: MODE=0x0000, src[2]=1 -> ivec=2; iack -> ivec stays 2; src[2]=0 -> ivec=0 next cycle.
REQ-032 Collision: iack on ivec=4 in the same cycle as new src[4] edge -> PEND[4] stays 1, ivec=4.
REQ-033 Mask (IRQ_MASK_EN): ENA=0x0000, SWSET 0x0080 -> irq=0, PEND reads 0x0080; ENA=0xFFFE -> ivec=7 next cycle; without macro, ENA reads 0xFFFE after write of 0.
REQ-034 Reset: arstn low while PEND=0x0106 -> PEND, irq, ivec, dout all 0 immediately, asynchronously to clk.
